// File: rtl/obc_dft_pkg.sv
// ---------------------------------------------------------------------------
// obc_dft_pkg
// Shared definitions for the OBC 16-point DFT datapath.
//   WORD_W    : ROM partial-word width (two's complement)
//   FRAC_BITS : fraction bits carried by a ROM word
//   NUM_TERMS : ROM words per bit-plane (one per sample pair)
//   SUM_W     : width of the full-precision 8-word sum (3 bits of growth)
//   obc_acc_state_t : shift-accumulator FSM state
//   obc_sext  : sign-extends the low n bits of a 64-bit vector
// ---------------------------------------------------------------------------
package obc_dft_pkg;

  localparam int WORD_W    = 32;
  localparam int FRAC_BITS = 21;
  localparam int NUM_TERMS = 8;
  localparam int SUM_W     = WORD_W + 3;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } obc_acc_state_t;

  // Treat bit n-1 of v as the sign bit and replicate it across the upper bits.
  function automatic logic signed [63:0] obc_sext(input logic [63:0] v,
                                                  input int unsigned n);
    logic [63:0] t;
    t = v << (64 - n);
    return $signed(t) >>> (64 - n);
  endfunction

endpackage

// File: rtl/obc_adder_tree.sv
// ---------------------------------------------------------------------------
// obc_adder_tree
// Balanced 8 x WORD_W -> SUM_W signed adder tree for one bit-plane.
// Optional macro: OBC_SUM_PIPE_EN -- registers the sum together with its
// valid bit, the MSB-plane tag and the offset sampled with that plane.
// Without the macro the tree is purely combinational and the tag/offset
// pass straight through.
// Ports:
//   clk, rst, flush  (OBC_SUM_PIPE_EN only) clock, async reset, sync clear
//   in_fire          plane accepted this cycle
//   in_last          accepted plane is the MSB plane
//   in_offset        OBC offset presented with the plane
//   rom_words        NUM_TERMS packed ROM words, word i at [i*WORD_W +: WORD_W]
//   sum_valid        sum is available for accumulation
//   sum_last         sum belongs to the MSB plane
//   sum_offset       offset travelling with the sum
//   sum              sign-extended total of the 8 words
// ---------------------------------------------------------------------------
module obc_adder_tree
  import obc_dft_pkg::*;
(
`ifdef OBC_SUM_PIPE_EN
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
`endif
  input  logic                          in_fire,
  input  logic                          in_last,
  input  logic [WORD_W-1:0]             in_offset,
  input  logic [NUM_TERMS*WORD_W-1:0]   rom_words,
  output logic                          sum_valid,
  output logic                          sum_last,
  output logic [WORD_W-1:0]             sum_offset,
  output logic signed [SUM_W-1:0]       sum
);

  logic signed [WORD_W-1:0] w  [NUM_TERMS];
  logic signed [WORD_W:0]   l1 [NUM_TERMS/2];
  logic signed [WORD_W+1:0] l2 [NUM_TERMS/4];
  logic signed [SUM_W-1:0]  sum_c;

  // Each level widens by one bit; signed size casts sign-extend the operands
  // so no level can overflow.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TERMS; gi++) begin : g_word
      assign w[gi] = rom_words[gi*WORD_W +: WORD_W];
    end
    for (gi = 0; gi < NUM_TERMS/2; gi++) begin : g_lvl1
      assign l1[gi] = (WORD_W+1)'(w[2*gi]) + (WORD_W+1)'(w[2*gi+1]);
    end
    for (gi = 0; gi < NUM_TERMS/4; gi++) begin : g_lvl2
      assign l2[gi] = (WORD_W+2)'(l1[2*gi]) + (WORD_W+2)'(l1[2*gi+1]);
    end
  endgenerate

  assign sum_c = SUM_W'(l2[0]) + SUM_W'(l2[1]);

`ifdef OBC_SUM_PIPE_EN
  logic                    valid_q;
  logic                    last_q;
  logic [WORD_W-1:0]       offset_q;
  logic signed [SUM_W-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      offset_q <= '0;
      sum_q    <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_fire;
      if (in_fire) begin
        sum_q    <= sum_c;
        last_q   <= in_last;
        offset_q <= in_offset;
      end
    end
  end

  assign sum_valid  = valid_q;
  assign sum_last   = last_q;
  assign sum_offset = offset_q;
  assign sum        = sum_q;
`else
  assign sum_valid  = in_fire;
  assign sum_last   = in_last;
  assign sum_offset = in_offset;
  assign sum        = sum_c;
`endif

endmodule

// File: rtl/obc_shift_accumulator.sv
// ---------------------------------------------------------------------------
// obc_shift_accumulator
// Bit-serial shift-accumulate stage of the OBC DFT. Per accepted bit-plane the
// eight ROM words are summed (obc_adder_tree) and accumulated LSB-first; the
// MSB plane is subtracted and the OBC offset added, producing one full-
// precision bin component per frame behind a valid/ready handshake.
// Optional macro: OBC_SUM_PIPE_EN -- registered adder-tree output, result
// latency 2 instead of 1; arithmetic is identical.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush          synchronous abort of the current frame / pending result
//   in_valid/in_ready  bit-plane handshake
//   rom_words      NUM_TERMS ROM words for the current plane
//   offset         OBC initial-value constant, taken with the MSB plane
//   out_valid/out_ready handshake for out_data
//   out_data       result, LSB weight 2^-(21+DATA_BITS-1)
//   busy           part of a frame has been accepted
// ---------------------------------------------------------------------------
module obc_shift_accumulator
  import obc_dft_pkg::*;
#(
  parameter  int DATA_BITS = 16,
  parameter  int WORD_W    = obc_dft_pkg::WORD_W,
  parameter  int NUM_TERMS = obc_dft_pkg::NUM_TERMS,
  localparam int ACC_W     = WORD_W + 5 + DATA_BITS - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_TERMS*WORD_W-1:0] rom_words,
  input  logic [WORD_W-1:0]           offset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        busy
);

  // Guard bits keep the right shifts exact: each plane's sum enters the
  // accumulator pre-scaled by 2^G and is halved once per later plane.
  localparam int G     = DATA_BITS - 1;
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  obc_acc_state_t          state_q;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_valid_q;

  logic                    plane_fire;
  logic                    plane_last;
  logic                    sum_valid;
  logic                    sum_last;
  logic [WORD_W-1:0]       sum_offset;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] s_sh;
  logic signed [ACC_W-1:0] off_sh;

`ifdef OBC_SUM_PIPE_EN
  // A registered MSB sum still waiting to be folded in blocks the next frame.
  assign in_ready = (state_q == ACC) && !(sum_valid && sum_last);
  assign busy     = (bit_cnt_q != '0) || sum_valid;
`else
  assign in_ready = (state_q == ACC);
  assign busy     = (bit_cnt_q != '0);
`endif

  assign plane_fire = in_valid && in_ready && !flush;
  assign plane_last = (bit_cnt_q == LAST_CNT);
  assign bit_cnt_d  = plane_last ? '0 : bit_cnt_q + CNT_W'(1);

  obc_adder_tree u_tree (
`ifdef OBC_SUM_PIPE_EN
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
`endif
    .in_fire    (plane_fire),
    .in_last    (plane_last),
    .in_offset  (offset),
    .rom_words  (rom_words),
    .sum_valid  (sum_valid),
    .sum_last   (sum_last),
    .sum_offset (sum_offset),
    .sum        (sum)
  );

  assign s_sh   = ACC_W'(obc_sext({{(64-SUM_W){1'b0}}, sum}, SUM_W) <<< G);
  assign off_sh = ACC_W'(obc_sext({{(64-WORD_W){1'b0}}, sum_offset}, WORD_W) <<< G);

  assign acc_d      = (acc_q + s_sh) >>> 1;
  // Sign plane carries negative weight in two's complement.
  assign out_data_d = acc_q - s_sh + off_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ACC;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (plane_fire) begin
            bit_cnt_q <= bit_cnt_d;
          end
          if (sum_valid) begin
            if (sum_last) begin
              out_data_q  <= out_data_d;
              acc_q       <= '0;
              state_q     <= OUT;
              out_valid_q <= 1'b1;
            end else begin
              acc_q <= acc_d;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= ACC;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACC;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
